// File: rtl/sr_sipo_if.sv
// Bus between the serial link, the sr_sipo_rx receiver and its parallel consumer.
// master = receiver view (drives the parallel side), slave = link/consumer view.
interface sr_sipo_if #(
  parameter int WIDTH = 4
);
  logic             si_valid;
  logic             sof;
  logic             si;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             busy;
  logic             overrun;
`ifdef SR_SIPO_PARITY_EN
  logic             parity_err;

  modport master (
    input  si_valid, sof, si, po_ready,
    output po, po_valid, busy, overrun, parity_err
  );
  modport slave (
    output si_valid, sof, si, po_ready,
    input  po, po_valid, busy, overrun, parity_err
  );
`else
  modport master (
    input  si_valid, sof, si, po_ready,
    output po, po_valid, busy, overrun
  );
  modport slave (
    output si_valid, sof, si, po_ready,
    input  po, po_valid, busy, overrun
  );
`endif
endinterface

// File: rtl/sr_sipo_rx.sv
// Serial-in/parallel-out receiver: sof-framed strobed bits assembled into a word with valid/ready output.
// Optional even-parity trailer bit when SR_SIPO_PARITY_EN is defined (adds parity_err).
module sr_sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  sr_sipo_if.master bus
);
`ifdef SR_SIPO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             complete, xfer;
  logic [WIDTH-1:0] word;
`ifdef SR_SIPO_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
  logic             word_perr;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r    = cur << 1;
      r[0] = b;
    end else begin
      r          = cur >> 1;
      r[WIDTH-1] = b;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    po_d       = po_q;
    po_valid_d = po_valid_q;
    overrun_d  = 1'b0;
    complete   = 1'b0;
    word       = sh_q;
    xfer       = po_valid_q & bus.po_ready;
`ifdef SR_SIPO_PARITY_EN
    par_d      = par_q;
    perr_d     = perr_q;
    word_perr  = 1'b0;
`endif

    if (xfer) po_valid_d = 1'b0;

    // sof restarts from an empty register in either state; the partial word is simply discarded
    if (bus.si_valid) begin
      if (bus.sof) begin
        if (NBITS == 1) begin
          complete = 1'b1;
          word     = shift_in('0, bus.si);
          state_d  = IDLE;
          cnt_d    = '0;
          sh_d     = '0;
        end else begin
          sh_d    = shift_in('0, bus.si);
          cnt_d   = CW'(1);
          state_d = SHIFT;
`ifdef SR_SIPO_PARITY_EN
          par_d   = bus.si;
`endif
        end
      end else if (state_q == SHIFT) begin
        if (int'(cnt_q) == NBITS - 1) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
          sh_d     = '0;
`ifdef SR_SIPO_PARITY_EN
          word      = sh_q;
          word_perr = par_q ^ bus.si;
`else
          word      = shift_in(sh_q, bus.si);
`endif
        end else begin
          sh_d  = shift_in(sh_q, bus.si);
          cnt_d = cnt_q + 1'b1;
`ifdef SR_SIPO_PARITY_EN
          par_d = par_q ^ bus.si;
`endif
        end
      end
    end

    if (complete) begin
      if (!po_valid_q || xfer) begin
        po_d       = word;
        po_valid_d = 1'b1;
`ifdef SR_SIPO_PARITY_EN
        perr_d     = word_perr;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef SR_SIPO_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
`ifdef SR_SIPO_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign bus.po       = po_q;
  assign bus.po_valid = po_valid_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;
`ifdef SR_SIPO_PARITY_EN
  assign bus.parity_err = perr_q;
`endif
endmodule
